ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 251 +++++++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
`timescale 1ns/1ps
// ps2_key_tracker: decodes PS/2 set-2 scan bytes into held-key state, stretched press/release pulses and an event FIFO.
// Latency: key_state, pulse start and ev_valid change on the clock edge after the rx_valid cycle (no FIFO bypass).
// Backpressure: ev_ready pops the FIFO; a push into a full FIFO with no same-cycle pop is dropped and sets sticky overflow.
//
// Ports:
//   CLOCK_50      system clock; every register is on its rising edge
//   reset         synchronous, active-high; wins over a simultaneous rx_valid
//   rx_data/rx_valid  received byte and its one-clock qualifier
//   key_state     one bit per tracked key, 1 while held
//   press_pulse / release_pulse  high for PULSE_CYCLES clocks after a press / release
//   ev_data/ev_valid/ev_ready    {is_make, key_index} events, popped on ev_valid & ev_ready
//   overflow      sticky: an event was dropped
// Build option: define KEY_EVENT_FIFO_EN to include the event FIFO; otherwise ev_* and overflow are tied to 0.

`ifndef keyTilda
`define keyTilda     0
`define keyNum1      1
`define keyNum2      2
`define keyNum3      3
`define keyNum4      4
`define keyNum5      5
`define keyNum6      6
`define keyNum7      7
`define keyNum8      8
`define keyNum9      9
`define keyNum0      10
`define keyQ         11
`define keyW         12
`define keyE         13
`define keyR         14
`define keyT         15
`define keyY         16
`define keyU         17
`define keyI         18
`define keyO         19
`define keyP         20
`define keyA         21
`define keyS         22
`define keyD         23
`define keyF         24
`define keyG         25
`define keyH         26
`define keyJ         27
`define keySpacebar  28
`endif

module ps2_key_tracker #(
    parameter int NUM_KEYS     = 29,
    parameter int FIFO_DEPTH   = 8,
    parameter int PULSE_CYCLES = 16
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic [NUM_KEYS-1:0]         key_state,
    output logic                        press_pulse,
    output logic                        release_pulse,
    output logic [$clog2(NUM_KEYS):0]   ev_data,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic                        overflow
);

    localparam int IW = $clog2(NUM_KEYS);
    localparam int EW = IW + 1;
    localparam int CW = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BRK    = 2'd1,
        EXT    = 2'd2,
        EXTBRK = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [CW-1:0]       press_cnt_q, press_cnt_d;
    logic [CW-1:0]       rel_cnt_q, rel_cnt_d;

    // Scan code -> key index lookup
    logic       map_hit;
    logic [4:0] map_idx;

    always_comb begin
        map_hit = 1'b1;
        map_idx = 5'd0;
        case (rx_data)
            8'h0E: map_idx = 5'(`keyTilda);
            8'h16: map_idx = 5'(`keyNum1);
            8'h1E: map_idx = 5'(`keyNum2);
            8'h26: map_idx = 5'(`keyNum3);
            8'h25: map_idx = 5'(`keyNum4);
            8'h2E: map_idx = 5'(`keyNum5);
            8'h36: map_idx = 5'(`keyNum6);
            8'h3D: map_idx = 5'(`keyNum7);
            8'h3E: map_idx = 5'(`keyNum8);
            8'h46: map_idx = 5'(`keyNum9);
            8'h45: map_idx = 5'(`keyNum0);
            8'h15: map_idx = 5'(`keyQ);
            8'h1D: map_idx = 5'(`keyW);
            8'h24: map_idx = 5'(`keyE);
            8'h2D: map_idx = 5'(`keyR);
            8'h2C: map_idx = 5'(`keyT);
            8'h35: map_idx = 5'(`keyY);
            8'h3C: map_idx = 5'(`keyU);
            8'h43: map_idx = 5'(`keyI);
            8'h44: map_idx = 5'(`keyO);
            8'h4D: map_idx = 5'(`keyP);
            8'h1C: map_idx = 5'(`keyA);
            8'h1B: map_idx = 5'(`keyS);
            8'h23: map_idx = 5'(`keyD);
            8'h2B: map_idx = 5'(`keyF);
            8'h34: map_idx = 5'(`keyG);
            8'h33: map_idx = 5'(`keyH);
            8'h3B: map_idx = 5'(`keyJ);
            8'h29: map_idx = 5'(`keySpacebar);
            default: map_hit = 1'b0;
        endcase
    end

    // A smaller NUM_KEYS simply leaves the upper codes unmapped.
    logic                key_hit;
    logic [NUM_KEYS-1:0] key_onehot;
    logic                key_is_set;

    assign key_hit    = map_hit && (32'(map_idx) < 32'(NUM_KEYS));
    assign key_onehot = NUM_KEYS'(1) << map_idx;
    assign key_is_set = |(key_state_q & key_onehot);

    // Decode FSM; make/break strobes are gated by reset so reset wins.
    logic make_vld, brk_vld;

    always_comb begin
        state_d  = state_q;
        make_vld = 1'b0;
        brk_vld  = 1'b0;
        if (rx_valid && !reset) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == 8'hF0)      state_d = BRK;
                    else if (rx_data == 8'hE0) state_d = EXT;
                    else if (key_hit)          make_vld = 1'b1;
                end
                BRK: begin
                    if (rx_data != 8'hF0) begin
                        state_d = IDLE;
                        brk_vld = key_hit;
                    end
                end
                EXT: begin
                    if (rx_data == 8'hF0) state_d = EXTBRK;
                    else                  state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Typematic repeats and breaks of released keys produce nothing.
    logic press_ev, release_ev;
    assign press_ev   = make_vld && !key_is_set;
    assign release_ev = brk_vld && key_is_set;

    always_comb begin
        key_state_d = key_state_q;
        if (press_ev)   key_state_d = key_state_q | key_onehot;
        if (release_ev) key_state_d = key_state_q & ~key_onehot;
    end

    // Pulse stretchers: reload on each event, count down to zero.
    always_comb begin
        press_cnt_d = press_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        if (press_ev)                press_cnt_d = CW'(PULSE_CYCLES);
        else if (press_cnt_q != '0)  press_cnt_d = press_cnt_q - CW'(1);
        if (release_ev)              rel_cnt_d = CW'(PULSE_CYCLES);
        else if (rel_cnt_q != '0)    rel_cnt_d = rel_cnt_q - CW'(1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            key_state_q <= '0;
            press_cnt_q <= '0;
            rel_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            key_state_q <= key_state_d;
            press_cnt_q <= press_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
        end
    end

    assign key_state     = key_state_q;
    assign press_pulse   = (press_cnt_q != '0);
    assign release_pulse = (rel_cnt_q != '0);

`ifdef KEY_EVENT_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;

    logic          push, pop, full, do_write;
    logic [EW-1:0] push_dat;

    assign push     = press_ev || release_ev;
    assign push_dat = {press_ev, IW'(map_idx)};
    // Pop only qualifies on a non-empty FIFO, so push+pop while empty is a plain push.
    assign pop      = (count_q != '0) && ev_ready;
    assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
    // While full, a same-cycle pop frees the slot being written.
    assign do_write = push && (!full || pop);

    always_ff @(posedge CLOCK_50) begin
        if (do_write) mem_q[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_write && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (!do_write && pop) count_q <= count_q - (AW+1)'(1);
            if (push && !do_write)     overflow_q <= 1'b1;
        end
    end

    // Masked when empty so the output reads zero out of reset.
    assign ev_valid = (count_q != '0);
    assign ev_data  = ev_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow = overflow_q;
`else
    logic unused_ev_ready;
    assign unused_ev_ready = ev_ready;
    assign ev_valid = 1'b0;
    assign ev_data  = '0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
`timescale 1ns/1ps

`ifndef keyTilda
`define keyTilda     0
`define keyNum1      1
`define keyNum2      2
`define keyNum3      3
`define keyNum4      4
`define keyNum5      5
`define keyNum6      6
`define keyNum7      7
`define keyNum8      8
`define keyNum9      9
`define keyNum0      10
`define keyQ         11
`define keyW         12
`define keyE         13
`define keyR         14
`define keyT         15
`define keyY         16
`define keyU         17
`define keyI         18
`define keyO         19
`define keyP         20
`define keyA         21
`define keyS         22
`define keyD         23
`define keyF         24
`define keyG         25
`define keyH         26
`define keyJ         27
`define keySpacebar  28
`endif

module tb_ps2_key_tracker;

`ifdef KEY_EVENT_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [28:0] key_state;
    logic        press_pulse, release_pulse;
    logic [5:0]  ev_data;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    ps2_key_tracker #(.NUM_KEYS(29), .FIFO_DEPTH(8), .PULSE_CYCLES(16)) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .ev_data       (ev_data),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .overflow      (overflow)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  code;
        logic [28:0] exp_keys;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [28:0] K(input int i);
        logic [28:0] one;
        one = 29'd1;
        return one << i;
    endfunction

    function automatic logic [5:0] EV(input bit mk, input int idx);
        logic [4:0] i5;
        i5 = 5'(idx);
        return {mk, i5};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts consecutive high cycles of the chosen pulse starting now (bounded).
    task automatic measure(input bit rel, output int n);
        n = 0;
        while (((rel ? release_pulse : press_pulse) == 1'b1) && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pop_check(input string name, input logic [5:0] exp);
        check({name, " valid"}, 64'(ev_valid), 64'(1));
        check({name, " data"}, 64'(ev_data), 64'(exp));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    logic [7:0] codes9 [9];
    int         idx9   [9];
    int         n;

    initial begin
        vecs.push_back('{8'h15, K(`keyQ)});
        vecs.push_back('{8'h15, K(`keyQ)});
        vecs.push_back('{8'h1D, K(`keyQ) | K(`keyW)});
        vecs.push_back('{8'hF0, K(`keyQ) | K(`keyW)});
        vecs.push_back('{8'h15, K(`keyW)});
        vecs.push_back('{8'hF0, K(`keyW)});
        vecs.push_back('{8'h15, K(`keyW)});
        vecs.push_back('{8'h77, K(`keyW)});
        vecs.push_back('{8'hF0, K(`keyW)});
        vecs.push_back('{8'hF0, K(`keyW)});
        vecs.push_back('{8'h1D, 29'd0});
        vecs.push_back('{8'hE0, 29'd0});
        vecs.push_back('{8'h29, 29'd0});
        vecs.push_back('{8'h29, K(`keySpacebar)});
        vecs.push_back('{8'hE0, K(`keySpacebar)});
        vecs.push_back('{8'hF0, K(`keySpacebar)});
        vecs.push_back('{8'h29, K(`keySpacebar)});
        vecs.push_back('{8'hF0, K(`keySpacebar)});
        vecs.push_back('{8'h29, 29'd0});
        vecs.push_back('{8'hF0, 29'd0});
        vecs.push_back('{8'h77, 29'd0});
        vecs.push_back('{8'h16, K(`keyNum1)});
        vecs.push_back('{8'h0E, K(`keyNum1) | K(`keyTilda)});
        vecs.push_back('{8'hF0, K(`keyNum1) | K(`keyTilda)});
        vecs.push_back('{8'h0E, K(`keyNum1)});

        codes9 = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        idx9   = '{`keyQ, `keyW, `keyE, `keyR, `keyT, `keyY, `keyU, `keyI, `keyO};

        // Reset state
        do_reset();
        check("reset key_state", 64'(key_state), 64'(0));
        check("reset press_pulse", 64'(press_pulse), 64'(0));
        check("reset release_pulse", 64'(release_pulse), 64'(0));
        check("reset ev_valid", 64'(ev_valid), 64'(0));
        check("reset ev_data", 64'(ev_data), 64'(0));
        check("reset overflow", 64'(overflow), 64'(0));

        // Decode table, FIFO drained continuously
        ev_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].code);
            check($sformatf("table[%0d] code %02h key_state", i, vecs[i].code),
                  64'(key_state), 64'(vecs[i].exp_keys));
        end
        ev_ready = 1'b0;

        // Single press: latency, pulse width, event
        do_reset();
        send(8'h15);
        check("press key_state", 64'(key_state), 64'(K(`keyQ)));
        check("press ev_valid", 64'(ev_valid), 64'(FIFO_EN));
        check("press ev_data", 64'(ev_data), FIFO_EN ? 64'(EV(1, `keyQ)) : 64'(0));
        measure(1'b0, n);
        check("press pulse width", 64'(n), 64'(16));

        // Typematic repeats: one entry, pulse not restarted; then break
        do_reset();
        send(8'h15);
        send(8'h15);
        send(8'h15);
        measure(1'b0, n);
        check("repeat pulse remaining", 64'(n), 64'(12));
`ifdef KEY_EVENT_FIFO_EN
        pop_check("repeat entry", EV(1, `keyQ));
        check("repeat single entry", 64'(ev_valid), 64'(0));
`endif
        send(8'hF0);
        send(8'h15);
        check("break key_state", 64'(key_state), 64'(0));
        check("break press_pulse", 64'(press_pulse), 64'(0));
        measure(1'b1, n);
        check("release pulse width", 64'(n), 64'(16));
`ifdef KEY_EVENT_FIFO_EN
        pop_check("break entry", EV(0, `keyQ));
        check("break single entry", 64'(ev_valid), 64'(0));
`else
        check("break ev_valid", 64'(ev_valid), 64'(0));
`endif

        // Extended sequences have no effect
        do_reset();
        send(8'hE0); send(8'h29); send(8'hE0); send(8'hF0); send(8'h29);
        check("ext key_state", 64'(key_state[`keySpacebar]), 64'(0));
        check("ext ev_valid", 64'(ev_valid), 64'(0));
        check("ext press_pulse", 64'(press_pulse), 64'(0));
        check("ext release_pulse", 64'(release_pulse), 64'(0));

        // Nine presses with no pops
        do_reset();
        for (int i = 0; i < 8; i++) send(codes9[i]);
        check("fill 8 overflow", 64'(overflow), 64'(0));
        send(codes9[8]);
        check("fill 9 key_state O", 64'(key_state[`keyO]), 64'(1));
        check("fill 9 overflow", 64'(overflow), 64'(FIFO_EN));
`ifdef KEY_EVENT_FIFO_EN
        for (int i = 0; i < 8; i++)
            pop_check($sformatf("drain[%0d]", i), EV(1, idx9[i]));
        check("drain empty", 64'(ev_valid), 64'(0));
        check("drain overflow sticky", 64'(overflow), 64'(1));

        // Push and pop in the same cycle while full
        do_reset();
        for (int i = 0; i < 8; i++) send(codes9[i]);
        @(negedge clk);
        rx_data  = codes9[8];
        rx_valid = 1'b1;
        ev_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        ev_ready = 1'b0;
        check("full push+pop overflow", 64'(overflow), 64'(0));
        for (int i = 1; i < 9; i++)
            pop_check($sformatf("full pp[%0d]", i), EV(1, idx9[i]));
        check("full pp empty", 64'(ev_valid), 64'(0));

        // Push and pop in the same cycle while empty
        do_reset();
        ev_ready = 1'b1;
        send(8'h15);
        check("empty push+pop valid", 64'(ev_valid), 64'(1));
        check("empty push+pop data", 64'(ev_data), 64'(EV(1, `keyQ)));
        @(negedge clk);
        check("empty push+pop popped", 64'(ev_valid), 64'(0));
        ev_ready = 1'b0;
`else
        check("nofifo ev_valid", 64'(ev_valid), 64'(0));
        check("nofifo ev_data", 64'(ev_data), 64'(0));
`endif

        // Reset mid-sequence discards the pending break
        do_reset();
        send(8'hF0);
        do_reset();
        send(8'h1D);
        check("midreset key W", 64'(key_state), 64'(K(`keyW)));
        check("midreset ev_data", 64'(ev_data), FIFO_EN ? 64'(EV(1, `keyW)) : 64'(0));
`ifdef KEY_EVENT_FIFO_EN
        pop_check("midreset entry", EV(1, `keyW));
        check("midreset single entry", 64'(ev_valid), 64'(0));
`endif

        // Reset wins over a simultaneous byte
        @(negedge clk);
        reset    = 1'b1;
        rx_data  = 8'h15;
        rx_valid = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        check("reset priority key_state", 64'(key_state), 64'(0));
        check("reset priority pulse", 64'(press_pulse), 64'(0));
        check("reset priority ev_valid", 64'(ev_valid), 64'(0));

        // Key 1 press
        do_reset();
        send(8'h16);
        check("key1 state", 64'(key_state[`keyNum1]), 64'(1));
        check("key1 ev_valid", 64'(ev_valid), 64'(FIFO_EN));
        measure(1'b0, n);
        check("key1 pulse width", 64'(n), 64'(16));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
